// File: rtl/led_pkg.sv
// Shared mode encodings for the multi-channel LED breathing controller.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BREATH = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

endpackage

// File: rtl/led_breath_ch.sv
// One LED channel: breathing duty ramp, blink divider and registered LED drive.
// All state updates happen on the shared frame_end strobe from the top.
module led_breath_ch
  import led_pkg::*;
#(
  parameter int PWM_PERIOD   = 50000,
  parameter int STEP         = 25,
  parameter int BLINK_FRAMES = 500,
  localparam int CW = $clog2(PWM_PERIOD),
  localparam int DW = $clog2(PWM_PERIOD + 1),
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              restart,
  input  logic              frame_end,
  input  logic [CW-1:0]     cnt,
  input  logic [MODE_W-1:0] mode,
  output logic              led
);

  localparam logic [DW:0] STEP_X   = (DW + 1)'(STEP);
  localparam logic [DW:0] PERIOD_X = (DW + 1)'(PWM_PERIOD);

  logic [DW-1:0] duty;
  logic          dir;
  logic [BW-1:0] bcnt;
  logic          bstate;
  mode_e         prev_mode;
  mode_e         cur_mode;
  logic [DW:0]   up_sum;
  logic          clear;

  assign cur_mode = mode_e'(mode);
  // One bit of headroom so the ramp can saturate at PWM_PERIOD without wrapping.
  assign up_sum   = {1'b0, duty} + STEP_X;
  assign clear    = !valid || restart || (cur_mode != prev_mode);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      duty      <= '0;
      dir       <= 1'b1;
      bcnt      <= '0;
      bstate    <= 1'b0;
      prev_mode <= MODE_OFF;
      led       <= 1'b0;
    end else begin
      prev_mode <= cur_mode;

      if (clear) begin
        duty   <= '0;
        dir    <= 1'b1;
        bcnt   <= '0;
        bstate <= 1'b0;
      end else if (frame_end) begin
        case (cur_mode)
          MODE_BREATH: begin
            if (dir) begin
              if (up_sum >= PERIOD_X) begin
                duty <= DW'(PWM_PERIOD);
                dir  <= 1'b0;
              end else begin
                duty <= up_sum[DW-1:0];
              end
            end else begin
              if ({1'b0, duty} <= STEP_X) begin
                duty <= '0;
                dir  <= 1'b1;
              end else begin
                duty <= duty - DW'(STEP);
              end
            end
          end
          MODE_BLINK: begin
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
              bcnt   <= '0;
              bstate <= ~bstate;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
          default: ;
        endcase
      end

      if (!valid) begin
        led <= 1'b0;
      end else begin
        case (cur_mode)
          MODE_OFF:    led <= 1'b0;
          MODE_ON:     led <= 1'b1;
          MODE_BREATH: led <= (DW'(cnt) < duty);
          MODE_BLINK:  led <= bstate;
        endcase
      end
    end
  end

endmodule

// File: rtl/led_breath_multi.sv
// Multi-channel LED breathing/blink controller: shared PWM frame counter and
// frame_tick, with one led_breath_ch per channel.
module led_breath_multi
  import led_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int PWM_PERIOD   = 50000,
  parameter int STEP         = 25,
  parameter int BLINK_FRAMES = 500
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic                     restart,
  input  logic [MODE_W*N_CH-1:0]   mode,
  output logic [N_CH-1:0]          led,
  output logic                     frame_tick
);

  localparam int CW = $clog2(PWM_PERIOD);

  logic [CW-1:0] cnt;
  logic          frame_end;

  assign frame_end = valid && (cnt == CW'(PWM_PERIOD - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (!valid || restart || frame_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    led_breath_ch #(
      .PWM_PERIOD   (PWM_PERIOD),
      .STEP         (STEP),
      .BLINK_FRAMES (BLINK_FRAMES)
    ) u_ch (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .valid     (valid),
      .restart   (restart),
      .frame_end (frame_end),
      .cnt       (cnt),
      .mode      (mode[MODE_W*i +: MODE_W]),
      .led       (led[i])
    );
  end

endmodule

// File: tb/tb_led_breath_multi.sv
// Directed bench for led_breath_multi with a small 2-channel, 8-cycle-frame setup.
module tb_led_breath_multi;
  import led_pkg::*;

  localparam int N_CH         = 2;
  localparam int PWM_PERIOD   = 8;
  localparam int STEP         = 3;
  localparam int BLINK_FRAMES = 2;

  logic                sys_clk = 1'b0;
  logic                rst;
  logic                valid;
  logic                restart;
  logic [2*N_CH-1:0]   mode;
  logic [N_CH-1:0]     led;
  logic                frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  led_breath_multi #(
    .N_CH         (N_CH),
    .PWM_PERIOD   (PWM_PERIOD),
    .STEP         (STEP),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .valid      (valid),
    .restart    (restart),
    .mode       (mode),
    .led        (led),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_tick(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < budget);
    if (frame_tick !== 1'b1) chk($sformatf("%s timeout", tag), 0, 1);
  endtask

  // Called at a frame_tick sample; counts lit cycles over the following frame.
  task automatic measure(input string tag, input int e0, input int e1);
    int c0 = 0;
    int c1 = 0;
    int tk = 0;
    for (int k = 0; k < PWM_PERIOD; k++) begin
      step();
      c0 += int'(led[0]);
      c1 += int'(led[1]);
      tk += int'(frame_tick);
    end
    chk($sformatf("%s led0", tag), c0, e0);
    if (e1 >= 0) chk($sformatf("%s led1", tag), c1, e1);
    chk($sformatf("%s tick_count", tag), tk, 1);
    chk($sformatf("%s tick_last", tag), int'(frame_tick), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int exp0[7] = '{3, 6, 8, 5, 2, 0, 3};
    int exp1[7] = '{0, 8, 8, 0, 0, 8, 8};

    // ch0 BREATH, ch1 BLINK
    rst     = 1'b1;
    valid   = 1'b1;
    restart = 1'b0;
    mode    = {MODE_BLINK, MODE_BREATH};
    repeat (3) step();
    chk("rst led", int'(led), 0);
    chk("rst tick", int'(frame_tick), 0);
    rst = 1'b0;

    wait_tick("first", 20, n);
    chk("first tick latency", n, PWM_PERIOD);
    for (int i = 0; i < 7; i++) measure($sformatf("breath%0d", i), exp0[i], exp1[i]);

    // duty is 6 now; restart lands on the frame_end cycle
    repeat (PWM_PERIOD - 1) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart tick", int'(frame_tick), 1);
    measure("post_restart0", 0, -1);
    measure("post_restart1", 3, -1);

    // mid-frame restart must zero the frame counter
    repeat (3) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    wait_tick("restart_mid", 20, n);
    chk("restart_mid latency", n, PWM_PERIOD);
    measure("after_mid", 3, -1);

    // both BREATH, then ch0 switches to BLINK mid-frame
    rst  = 1'b1;
    mode = {MODE_BREATH, MODE_BREATH};
    repeat (2) step();
    rst = 1'b0;
    wait_tick("dual", 20, n);
    measure("dual0", 3, 3);
    repeat (3) step();
    mode = {MODE_BREATH, MODE_BLINK};
    wait_tick("chg", 20, n);
    chk("chg latency", n, PWM_PERIOD - 3);
    measure("chg0", 0, 8);
    measure("chg1", 8, 5);

    // valid drop for 5 cycles mid-frame; ch0 blink is lit going in
    repeat (2) step();
    chk("pre_drop led0", int'(led[0]), 1);
    valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("drop%0d led", k), int'(led), 0);
      chk($sformatf("drop%0d tick", k), int'(frame_tick), 0);
    end
    valid = 1'b1;
    wait_tick("resume", 20, n);
    chk("resume latency", n, PWM_PERIOD);
    measure("resume0", 0, 3);
    measure("resume1", 8, 6);

    // ch0 ON, ch1 OFF, applied while idle
    valid = 1'b0;
    mode  = {MODE_OFF, MODE_ON};
    repeat (2) step();
    chk("idle led", int'(led), 0);
    valid = 1'b1;
    step();
    chk("on led", int'(led), 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (led !== 2'b01) bad++;
    end
    chk("on constant", bad, 0);

    // synchronous reset mid-frame
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("mid rst led", int'(led), 0);
    chk("mid rst tick", int'(frame_tick), 0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (led !== 2'b00 || frame_tick !== 1'b0) bad++;
    end
    chk("rst held quiet", bad, 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_breath_multi.md
LED_BREATH_MULTI -- requirements
Module: led_breath_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent LED channels (1..16).
REQ-002 Parameter PWM_PERIOD, default 50000, sys_clk cycles per PWM frame (>=2); 1 ms at 50 MHz.
REQ-003 Parameter STEP, default 25, duty change per frame in BREATH mode (1..PWM_PERIOD).
REQ-004 Parameter BLINK_FRAMES, default 500, frames per half-period in BLINK mode (>=1).
REQ-005 sys_clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 valid  input  1  global run enable; low forces idle state.
REQ-008 restart  input  1  one-cycle pulse; resynchronises all channels.
REQ-009 mode  input  2*N_CH  per-channel mode, channel i at bits [2i+1:2i]: 0 OFF, 1 ON, 2 BREATH, 3 BLINK.
REQ-010 led  output  N_CH  per-channel LED drive, registered, 1 = lit.
REQ-011 frame_tick  output  1  registered one-cycle pulse in the cycle after the last cycle of each frame.

Function
REQ-012 Shared frame counter SHALL count 0..PWM_PERIOD-1 and wrap to 0; width $clog2(PWM_PERIOD).
REQ-013 frame_end SHALL be true when counter = PWM_PERIOD-1 and valid=1; frame_tick = frame_end delayed one cycle.
REQ-014 Each channel SHALL hold duty (width $clog2(PWM_PERIOD+1), range 0..PWM_PERIOD) and direction bit dir (1 = up).
REQ-015 BREATH, up, at frame_end: if duty+STEP >= PWM_PERIOD, duty<=PWM_PERIOD and dir<=0; else duty<=duty+STEP.
REQ-016 BREATH, down, at frame_end: if duty <= STEP, duty<=0 and dir<=1; else duty<=duty-STEP.
REQ-017 Duty arithmetic SHALL be compared in one bit of headroom; duty never exceeds PWM_PERIOD nor underflows.
REQ-018 BLINK: per-channel frame counter 0..BLINK_FRAMES-1 advanced at frame_end; blink state toggles on wrap; starts at 0 (dark).
REQ-019 led[i] next value: OFF -> 0; ON -> 1; BREATH -> (counter < duty); BLINK -> blink state. Latency 1 cycle from counter/state.
REQ-020 Change of mode[i] (registered compare against previous value) SHALL reset channel i to duty=0, dir=1, blink counter=0, blink state=0 in the next cycle; other channels unaffected.
REQ-021 restart=1 SHALL set frame counter 0 and every channel to duty=0, dir=1, blink counter/state=0 next cycle; restart overrides a coincident frame_end.
REQ-022 valid=0 SHALL hold frame counter at 0, all channels as after restart, led=0, frame_tick=0; run resumes from counter 0 when valid returns to 1.
REQ-023 Priority per cycle: rst > valid=0 > restart > mode change > frame_end update.
REQ-024 With defaults, one BREATH cycle (0 -> 50000 -> 0) SHALL take 4000 frames = 4 s.

Reset
REQ-025 rst=1 SHALL set frame counter 0, all duty 0, dir 1, blink counters/states 0, previous-mode registers 0 (OFF), led 0, frame_tick 0.
REQ-026 Reset is synchronous only; no asynchronous reset paths.

Structure
REQ-027 Mode encodings (OFF/ON/BREATH/BLINK) and the 2-bit mode width SHALL live in shared package led_pkg.
REQ-028 Per-channel duty/dir/blink/previous-mode logic SHALL be sub-module led_breath_ch, instantiated N_CH times via generate; frame counter and frame_tick stay in the top.

Verification (N_CH=2, PWM_PERIOD=8, STEP=3, BLINK_FRAMES=2 unless stated)
REQ-029 rst, valid=1, mode ch0=BREATH: duty sequence at successive frame_ends 3,6,8(dir down),5,2,0(dir up),3; led[0] high exactly duty cycles per frame.
REQ-030 ch1=BLINK: led[1] 0 for 16 cycles, 1 for 16 cycles, repeating; frame_tick every 8 cycles.
REQ-031 ch0=ON, ch1=OFF: led=2'b01 one cycle after valid rises, constant thereafter.
REQ-032 restart pulse coincident with frame_end while ch0 duty=6: next cycle counter=0, duty=0, dir=1; no increment applied.
REQ-033 Mode ch0 BREATH->BLINK mid-frame: ch0 resets (blink state 0), ch1 duty trajectory unchanged.
REQ-034 valid dropped for 5 cycles mid-run then raised: led=0 during drop; counter and duties restart from 0; rst asserted mid-frame clears all outputs on next edge.
